// File: rtl/otter_alu_md_if.sv
// otter_alu_md_if: start/busy/done request bus between the execute stage and the ALU
interface otter_alu_md_if #(
  parameter int WIDTH = 32
);
  logic             start_i;
  logic [4:0]       alu_fun_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] result_o;
  logic             zero_o;
  modport slave(
    input  start_i, alu_fun_i, a_i, b_i,
    output busy_o, done_o, result_o, zero_o
  );
  modport master(
    output start_i, alu_fun_i, a_i, b_i,
    input  busy_o, done_o, result_o, zero_o
  );
endinterface

// File: rtl/otter_alu_md.sv
// otter_alu_md: registered RV32I/RV32M ALU with an iterative shift-add multiplier and restoring divider
module otter_alu_md #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst_n,
  otter_alu_md_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0]   mb_q, mb_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               zero_q, zero_d;
  logic [4:0]         fun;
  logic [WIDTH-1:0]   a, b;
  logic [SHW-1:0]     sh;
  logic               is_m, sa_en, sb_en, sa, sb, ovf, special;
  logic [WIDTH-1:0]   ma, mb, base_res, quick_res;
  logic [WIDTH:0]     sum, cand, diff;
  logic               ge;
  logic [2*WIDTH-1:0] mul_nx, div_nx, step, prod;
  logic [WIDTH-1:0]   quo_s, rem_s, fin_res;
  assign fun = bus.alu_fun_i;
  assign a   = bus.a_i;
  assign b   = bus.b_i;
  assign sh  = b[SHW-1:0];
  // M-op decode: signedness of each operand and the early-completion cases
  assign is_m    = fun[4] & ~fun[3];
  assign sa_en   = fun[2] ? ~fun[0] : (fun[0] ^ fun[1]);
  assign sb_en   = fun[2] ? ~fun[0] : (fun[1:0] == 2'b01);
  assign sa      = a[WIDTH-1] & sa_en;
  assign sb      = b[WIDTH-1] & sb_en;
  assign ma      = sa ? -a : a;
  assign mb      = sb ? -b : b;
  assign ovf     = ~fun[0] & (a == {1'b1, {(WIDTH-1){1'b0}}}) & (b == '1);
  assign special = fun[2] & ((b == '0) | ovf);
  // single-cycle base operations; unlisted codes yield zero
  always_comb begin
    case (fun[3:0])
      4'd0:    base_res = a + b;
      4'd8:    base_res = a - b;
      4'd6:    base_res = a | b;
      4'd7:    base_res = a & b;
      4'd4:    base_res = a ^ b;
      4'd5:    base_res = a >> sh;
      4'd1:    base_res = a << sh;
      4'd13:   base_res = $signed(a) >>> sh;
      4'd2:    base_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd3:    base_res = {{(WIDTH-1){1'b0}}, a < b};
      4'd9:    base_res = a;
      default: base_res = '0;
    endcase
  end
  assign quick_res = !is_m ? (fun[4] ? '0 : base_res)
                   : (b == '0) ? (fun[1] ? a : '1)
                   : (fun[1] ? '0 : a);
  // one iteration of the unsigned core: p_q holds {acc, multiplier} or {remainder, quotient}
  assign sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, mb_q} : '0);
  assign mul_nx = {sum, p_q[WIDTH-1:1]};
  assign cand   = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
  assign diff   = cand - {1'b0, mb_q};
  assign ge     = ~diff[WIDTH];
  assign div_nx = {ge ? diff[WIDTH-1:0] : cand[WIDTH-1:0], p_q[WIDTH-2:0], ge};
  assign step   = op_q[2] ? div_nx : mul_nx;
  // sign correction applied to the final iteration's value
  assign prod    = neg_q ? -step : step;
  assign quo_s   = neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem_s   = neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  assign fin_res = op_q[2] ? (op_q[1] ? rem_s : quo_s)
                 : (op_q[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
  // next-state: accept in IDLE/FIN, iterate in CALC
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p_d      = p_q;
    mb_d     = mb_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    if (state_q == CALC) begin
      p_d   = step;
      cnt_d = cnt_q + SHW'(1);
      if (cnt_q == SHW'(WIDTH-1)) begin
        result_d = fin_res;
        state_d  = FIN;
      end
    end else begin
      state_d = IDLE;
      if (bus.start_i) begin
        if (!is_m || special) begin
          result_d = quick_res;
          state_d  = FIN;
        end else begin
          p_d     = {{WIDTH{1'b0}}, ma};
          mb_d    = mb;
          op_d    = fun[2:0];
          neg_d   = (fun[2] & fun[1]) ? sa : (sa ^ sb);
          cnt_d   = '0;
          state_d = CALC;
        end
      end
    end
    zero_d = (result_d == '0);
  end
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      mb_q     <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p_q      <= p_d;
      mb_q     <= mb_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end
  assign bus.busy_o   = (state_q == CALC);
  assign bus.done_o   = (state_q == FIN);
  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
endmodule

// File: tb/tb_otter_alu_md.sv
// tb_otter_alu_md: directed vectors for the registered ALU / multiply-divide unit
module tb_otter_alu_md;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  otter_alu_md_if #(.WIDTH(32)) bus();
  otter_alu_md #(.WIDTH(32)) dut(.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  // issue one op from a point away from the clock edge and wait (bounded) for DONE
  task automatic run(input string tag, input logic [4:0] f, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat);
    int lat;
    int nb;
    int both;
    bus.start_i = 1'b1;
    bus.alu_fun_i = f;
    bus.a_i = a;
    bus.b_i = b;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    lat = 1;
    nb = 0;
    both = 0;
    while (!bus.done_o && lat < 40) begin
      if (bus.busy_o) nb++;
      @(posedge clk);
      #1 lat++;
    end
    if (bus.busy_o && bus.done_o) both++;
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_busy"}, nb, exp_lat == 1 ? 0 : 32);
    check({tag, "_bd"}, both, 0);
    check({tag, "_res"}, bus.result_o, exp);
    check({tag, "_zero"}, bus.zero_o, exp == 32'h0);
  endtask
  initial begin
    bus.start_i = 1'b0;
    bus.alu_fun_i = 5'd0;
    bus.a_i = '0;
    bus.b_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy_o, 0);
    check("rst_done", bus.done_o, 0);
    check("rst_res", bus.result_o, 32'h0);
    check("rst_zero", bus.zero_o, 1);
    @(negedge clk) rst_n = 1'b1;
    run("add", 5'd0, 32'd5, 32'd7, 32'h0000000C, 1);
    run("sub_b2b", 5'd8, 32'd3, 32'd5, 32'hFFFFFFFE, 1);
    @(posedge clk);
    #1 check("done_pulse", bus.done_o, 0);
    check("hold_res", bus.result_o, 32'hFFFFFFFE);
    run("or", 5'd6, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1);
    run("and", 5'd7, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1);
    run("xor", 5'd4, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1);
    run("srl", 5'd5, 32'h80000000, 32'h00000024, 32'h08000000, 1);
    run("sll", 5'd1, 32'h00000001, 32'h0000001F, 32'h80000000, 1);
    run("sra", 5'd13, 32'h80000000, 32'h0000003F, 32'hFFFFFFFF, 1);
    run("slt", 5'd2, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1);
    run("sltu", 5'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1);
    run("lui", 5'd9, 32'h12345000, 32'h00000077, 32'h12345000, 1);
    run("undef11", 5'd11, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    run("undef27", 5'd27, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1);
    run("mulhu", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run("mul", 5'd16, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33);
    run("mulh", 5'd17, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    run("mulhsu", 5'd18, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    run("mul_big", 5'd16, 32'h00012345, 32'h00010000, 32'h23450000, 33);
    run("div", 5'd20, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33);
    run("rem", 5'd22, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33);
    run("divu", 5'd21, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33);
    run("remu", 5'd23, 32'd100, 32'd7, 32'd2, 33);
    run("rem_posneg", 5'd22, 32'd7, 32'hFFFFFFFE, 32'd1, 33);
    run("div0", 5'd20, 32'h12345678, 32'h0, 32'hFFFFFFFF, 1);
    run("remu0", 5'd23, 32'h12345678, 32'h0, 32'h12345678, 1);
    run("div_ovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run("rem_ovf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    run("divu_min", 5'd21, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 33);
    run("divu_pre", 5'd21, 32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 33);
    bus.start_i = 1'b1;
    bus.alu_fun_i = 5'd16;
    bus.a_i = 32'd3;
    bus.b_i = 32'd5;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    bus.start_i = 1'b1;
    bus.alu_fun_i = 5'd0;
    bus.a_i = 32'd1;
    bus.b_i = 32'd1;
    @(posedge clk);
    #1 bus.start_i = 1'b0;
    check("ign_busy", bus.busy_o, 1);
    check("ign_done", bus.done_o, 0);
    check("ign_res", bus.result_o, 32'h7FFFFFFC);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy_o, 0);
    check("abort_done", bus.done_o, 0);
    check("abort_res", bus.result_o, 32'h0);
    check("abort_zero", bus.zero_o, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 check("post_rst_done", bus.done_o, 0);
    end
    run("add_after", 5'd0, 32'd5, 32'd7, 32'h0000000C, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
